output_deskew_buffer: RTL
=========================

// Module: output_deskew_buffer
// PURPOSE
//  Collects the column outputs of the systolic array, which leave the array skewed.
//  Column c delivers the element of output row k exactly c cycles after column 0 does.
//  Re-aligns them into whole rows, buffers up to DEPTH rows, and presents each row
//  downstream as one vector under a valid/ready handshake.
//  It is the drain-side counterpart of the skewed input feed at the array's other edge.
// PARAMETERS
//  SYS_COLS    4   number of systolic-array columns (one lane per column)
//  P_BITWIDTH  32  width of one partial-sum / result element
//  DEPTH       16  rows buffered per lane; power of two, >= 2
// PORTS
//  clk         in   1                     single clock, rising edge
//  rst         in   1                     reset, asynchronous, active-high
//  i_valid     in   SYS_COLS              per-column result strobe from array bottom edge
//  i_data      in   SYS_COLS x P_BITWIDTH per-column result, qualified by i_valid[c]
//  o_valid     out  1                     o_data holds one complete aligned row
//  o_ready     in   1                     downstream accepts the row this cycle
//  o_data      out  SYS_COLS x P_BITWIDTH aligned row; element c = column c
//  o_rows      out  $clog2(DEPTH)+1       complete rows held (= occupancy of lane SYS_COLS-1)
//  err_ovf     out  1                     sticky: a write hit a full lane and was dropped
//  err_skew    out  1                     sticky: column-order violation detected
// BEHAVIOUR
//  - One FIFO lane per column.
//    - Lane c has its own wr_ptr, rd_ptr and occupancy counter.
//    - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
//    - Occupancy runs 0..DEPTH.
//  - Write: when i_valid[c]=1, i_data[c] is written to lane c at the clock edge.
//  - Output is first-word fall-through:
//    - o_valid = every lane's occupancy > 0.
//    - o_data[c] = head of lane c, combinational.
//    - o_data is all-zero whenever o_valid=0.
//  - Pop: when o_valid & o_ready, all lanes advance rd_ptr together at the edge.
//    - Pop with o_valid=0 is ignored.
//  - Latency: the row whose last element arrives at edge N gives o_valid=1 right after edge N.
//    - In the skewed stream, the last element is column SYS_COLS-1.
//    - That is SYS_COLS-1 cycles after column 0 received the same row.
//  - Full lane:
//    - A write to a full lane, with no pop that cycle, is dropped.
//    - The lane is unchanged and err_ovf sets to 1.
//    - Write and pop in the same cycle on a full lane are both accepted; occupancy stays DEPTH.
//  - Empty lane: write and pop cannot coincide on an empty lane, because o_valid=0 blocks the pop.
//  - Skew check (for c >= 1):
//    - Register i_valid into v_d (1 cycle delay).
//    - If i_valid[c]=1 and v_d[c-1]=0, err_skew sets to 1.
//    - The write still proceeds.
//    - In cycle 0 after reset, v_d is all-zero, so any i_valid[c>=1] flags the error.
//  - Sticky errors: err_ovf and err_skew clear only on rst.
//  - Reset (async assert, released synchronously to clk by the top level):
//    - All pointers and occupancies go to 0, and v_d goes to 0.
//    - Outputs: o_valid=0, o_data=0, o_rows=0, err_ovf=0, err_skew=0.
//    - Reset mid-stream discards all buffered and partially aligned rows.
//    - Storage RAM contents need no reset.
//  - o_rows is the registered occupancy of lane SYS_COLS-1.
//    - It equals the count of complete rows, since that lane fills last.
// TESTING
//  1. Skewed burst, SYS_COLS=4: rows k=0..3 with data[c]=16*k+c, column c driven c cycles late.
//     -> o_valid rises 3 cycles after column 0's first write.
//     -> o_data = {3,2,1,0}, then {19,18,17,16}, and so on.
//     -> o_rows peaks at 4 with o_ready=0; err_*=0.
//  2. Backpressure: 16 skewed rows, o_ready=0 -> o_rows=16, no error.
//     -> A 17th row sets err_ovf=1 and is dropped.
//     -> Then o_ready=1 drains exactly rows 0..15 in order; o_valid=0 afterwards.
//  3. Streaming at full rate: o_ready=1 constantly, 40 skewed rows.
//     -> 40 rows out in order, back-to-back, o_rows <= 1, pointers wrap twice, no error.
//  4. Full with simultaneous pop: lane full, o_ready=1 while a new skewed row arrives.
//     -> Both operations are accepted, no err_ovf, and the total row count out is correct.
//  5. Skew fault: i_valid=4'b0010 in the first cycle after reset -> err_skew=1.
//     -> The flag holds through later traffic until rst.
//  6. Async reset mid-stream: assert rst while 3 rows are buffered, between clock edges.
//     -> All outputs drop to 0 immediately, without waiting for an edge.
//     -> After release, a fresh burst is delivered correctly.

Source files
------------

// File: rtl/output_deskew_buffer.sv
// Re-aligns the skewed column outputs of the systolic array into whole rows.
// Each column has its own FIFO lane; the rows leave as one vector under valid/ready.
module output_deskew_buffer #(
    parameter int SYS_COLS   = 4,
    parameter int P_BITWIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [SYS_COLS-1:0]                   i_valid,
    input  logic [SYS_COLS-1:0][P_BITWIDTH-1:0]   i_data,
    output logic                                  o_valid,
    input  logic                                  o_ready,
    output logic [SYS_COLS-1:0][P_BITWIDTH-1:0]   o_data,
    output logic [$clog2(DEPTH):0]                o_rows,
    output logic                                  err_ovf,
    output logic                                  err_skew
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYS_COLS-1:0] lane_nonempty;
    logic [SYS_COLS-1:0] lane_ovf;
    logic [SYS_COLS-1:0] lane_skew;
    logic [SYS_COLS-2:0] v_d_reg;
    logic [CW-1:0]       count_last;
    logic                pop;
    logic                err_ovf_reg;
    logic                err_skew_reg;

    assign o_valid = &lane_nonempty;
    assign pop     = o_valid & o_ready;

    generate
        for (genvar gi = 0; gi < SYS_COLS; gi++) begin : g_lane
            logic [P_BITWIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]         wr_ptr_reg;
            logic [AW-1:0]         rd_ptr_reg;
            logic [CW-1:0]         count_reg;
            logic                  full;
            logic                  wr_en;

            // A full lane still accepts a write when the same edge pops a row.
            assign full          = (count_reg == CW'(DEPTH));
            assign wr_en         = i_valid[gi] & (~full | pop);
            assign lane_ovf[gi]  = i_valid[gi] & full & ~pop;
            assign lane_nonempty[gi] = (count_reg != '0);
            assign o_data[gi]    = o_valid ? mem[rd_ptr_reg] : '0;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_ptr_reg] <= i_data[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                    case ({wr_en, pop})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Column c must follow column c-1 by exactly one cycle.
            if (gi == 0) begin : g_first
                assign lane_skew[gi] = 1'b0;
            end else begin : g_rest
                assign lane_skew[gi] = i_valid[gi] & ~v_d_reg[gi-1];
            end

            if (gi == SYS_COLS - 1) begin : g_last
                assign count_last = count_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_d_reg      <= '0;
            err_ovf_reg  <= 1'b0;
            err_skew_reg <= 1'b0;
        end else begin
            v_d_reg <= i_valid[SYS_COLS-2:0];
            if (|lane_ovf) begin
                err_ovf_reg <= 1'b1;
            end
            if (|lane_skew) begin
                err_skew_reg <= 1'b1;
            end
        end
    end

    // The last lane fills last, so its occupancy is the complete-row count.
    assign o_rows   = count_last;
    assign err_ovf  = err_ovf_reg;
    assign err_skew = err_skew_reg;

endmodule
